// File: rtl/exe_stage_pkg.sv
// Shared widths, execute command encoding and FSM state type for the execute stage.
package exe_stage_pkg;
  localparam int N = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int SHAMT_W = $clog2(N);

  typedef enum logic [3:0] {
    NOP, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL, DIVU, REMU
  } execmd_t;

  typedef enum logic {IDLE, BUSY} exe_state_t;

  function automatic logic is_multi(input execmd_t cmd);
    return (cmd == MUL) || (cmd == DIVU) || (cmd == REMU);
  endfunction
endpackage

// File: rtl/exe_stage_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
module muldiv_iter
  import exe_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               step,
  input  execmd_t            op,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic [SHAMT_W-1:0] cnt,
  output logic               done,
  output logic [N-1:0]       result
);
  execmd_t      op_q;
  logic [N-1:0] x_q, y_q, acc_q;
  logic [N-1:0] x_nx, y_nx, acc_nx;
  logic [N:0]   rem_sh, trial;

  // MUL: x=multiplicand, y=multiplier, acc=product. DIV: x=divisor, y=quotient/dividend, acc=remainder.
  // A zero divisor never yields a negative trial, so DIVU saturates to all ones and REMU returns a.
  always_comb begin
    rem_sh = {acc_q, y_q[N-1]};
    trial  = rem_sh - {1'b0, x_q};
    if (op_q == MUL) begin
      acc_nx = y_q[0] ? acc_q + x_q : acc_q;
      x_nx   = x_q << 1;
      y_nx   = y_q >> 1;
    end else begin
      acc_nx = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
      x_nx   = x_q;
      y_nx   = {y_q[N-2:0], ~trial[N]};
    end
    result = (op_q == DIVU) ? y_nx : acc_nx;
  end

  assign done = step && (cnt == SHAMT_W'(N-1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q  <= NOP;
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      op_q  <= op;
      x_q   <= (op == MUL) ? a : b;
      y_q   <= (op == MUL) ? b : a;
      acc_q <= '0;
      cnt   <= '0;
    end else if (step) begin
      x_q   <= x_nx;
      y_q   <= y_nx;
      acc_q <= acc_nx;
      cnt   <= cnt + SHAMT_W'(1);
    end
  end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative MUL/DIVU/REMU sequencing and the EX/MEM register.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  execmd_t                      exe_cmd,
  input  logic [N-1:0]                 val1,
  input  logic [N-1:0]                 val2,
  input  logic [N-1:0]                 st_value,
  input  logic [N-1:0]                 pc,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest,
  input  logic                         wb_en,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic                         br_taken,
  input  logic                         flush,
  output logic                         stall_out,
  output logic [N-1:0]                 alu_result,
  output logic [N-1:0]                 st_value_out,
  output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
  output logic                         wb_en_out,
  output logic                         mem_r_en_out,
  output logic                         mem_w_en_out,
  output logic                         br_taken_out,
  output logic [N-1:0]                 br_target
);
  exe_state_t         state, state_nx;
  logic               start, step, done, load;
  logic [SHAMT_W-1:0] cnt;
  logic [N-1:0]       md_result, alu_val, res;
  logic [SHAMT_W-1:0] shamt;

  assign start     = rstn && (state == IDLE) && is_multi(exe_cmd) && !flush;
  assign step      = rstn && (state == BUSY) && !flush;
  assign stall_out = start || (step && (cnt != SHAMT_W'(N-1)));
  assign shamt     = val2[SHAMT_W-1:0];

  muldiv_iter u_muldiv (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .step   (step),
    .op     (exe_cmd),
    .a      (val1),
    .b      (val2),
    .cnt    (cnt),
    .done   (done),
    .result (md_result)
  );

  always_comb begin
    alu_val = '0;
    case (exe_cmd)
      ADD:     alu_val = val1 + val2;
      SUB:     alu_val = val1 - val2;
      AND:     alu_val = val1 & val2;
      OR:      alu_val = val1 | val2;
      XOR:     alu_val = val1 ^ val2;
      SLL:     alu_val = val1 << shamt;
      SRL:     alu_val = val1 >> shamt;
      SRA:     alu_val = $unsigned($signed(val1) >>> shamt);
      SLT:     alu_val = N'($signed(val1) < $signed(val2));
      SLTU:    alu_val = N'(val1 < val2);
      default: alu_val = '0;
    endcase
  end

  // load=0 means the EX/MEM register takes a bubble this edge.
  always_comb begin
    load     = 1'b0;
    res      = alu_val;
    state_nx = IDLE;
    if (flush) begin
      state_nx = IDLE;
    end else if (state == IDLE) begin
      load     = !is_multi(exe_cmd);
      state_nx = is_multi(exe_cmd) ? BUSY : IDLE;
    end else if (done) begin
      load     = 1'b1;
      res      = md_result;
      state_nx = IDLE;
    end else begin
      state_nx = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      alu_result   <= '0;
      st_value_out <= '0;
      dest_out     <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      br_taken_out <= 1'b0;
      br_target    <= '0;
    end else begin
      state        <= state_nx;
      alu_result   <= load ? res : '0;
      st_value_out <= load ? st_value : '0;
      dest_out     <= load ? dest : '0;
      wb_en_out    <= load && wb_en;
      mem_r_en_out <= load && mem_r_en;
      mem_w_en_out <= load && mem_w_en;
      br_taken_out <= load && br_taken;
      br_target    <= load ? pc + val2 : '0;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage with hand-computed expected results.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic          clk, rstn, wb_en, mem_r_en, mem_w_en, br_taken, flush, stall_out;
  execmd_t       exe_cmd;
  logic [31:0]   val1, val2, st_value, pc;
  logic [4:0]    dest, dest_out;
  logic [31:0]   alu_result, st_value_out, br_target;
  logic          wb_en_out, mem_r_en_out, mem_w_en_out, br_taken_out;
  int            checks = 0;
  int            failures = 0;

  exe_stage dut (
    .clk(clk), .rstn(rstn), .exe_cmd(exe_cmd), .val1(val1), .val2(val2),
    .st_value(st_value), .pc(pc), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .br_taken(br_taken), .flush(flush), .stall_out(stall_out),
    .alu_result(alu_result), .st_value_out(st_value_out), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .br_taken_out(br_taken_out), .br_target(br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input execmd_t c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    exe_cmd  = c;
    val1     = a;
    val2     = b;
    dest     = d;
    wb_en    = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    br_taken = 1'b0;
    st_value = 32'h5a5a_0000 | 32'(d);
    pc       = 32'h0000_0100;
    flush    = 1'b0;
    #1;
  endtask

  task automatic alu(input string tag, input execmd_t c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    drv(c, a, b, 5'd3);
    chk({tag, "_nostall"}, 32'(stall_out), 32'd0);
    tick();
    chk(tag, alu_result, exp);
  endtask

  task automatic multi(input string tag, input execmd_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    int bad;
    n = 0;
    bad = 0;
    drv(c, a, b, 5'd9);
    while (stall_out && n < 40) begin
      tick();
      n++;
      if (wb_en_out || alu_result != 32'd0) bad++;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd32);
    chk({tag, "_bubbles"}, 32'(bad), 32'd0);
    tick();
    chk(tag, alu_result, exp);
    chk({tag, "_dest"}, 32'(dest_out), 32'd9);
    chk({tag, "_wb"}, 32'(wb_en_out), 32'd1);
  endtask

  initial begin
    rstn = 1'b0;
    drv(MUL, $urandom, $urandom, 5'($urandom));
    mem_r_en = 1'b1;
    mem_w_en = 1'b1;
    br_taken = 1'b1;
    repeat (2) tick();
    chk("rst_alu", alu_result, 32'd0);
    chk("rst_st", st_value_out, 32'd0);
    chk("rst_dest", 32'(dest_out), 32'd0);
    chk("rst_flags", {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, br_taken_out}, 32'd0);
    chk("rst_brt", br_target, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    rstn = 1'b1;

    drv(ADD, 32'hffff_ffff, 32'd1, 5'd3);
    tick();
    chk("add_wrap", alu_result, 32'd0);
    chk("add_dest", 32'(dest_out), 32'd3);
    chk("add_wb", 32'(wb_en_out), 32'd1);
    chk("add_brt", br_target, 32'h0000_0101);

    alu("sub", SUB, 32'd3, 32'd5, 32'hffff_fffe);
    alu("sra", SRA, 32'h8000_0000, 32'd4, 32'hf800_0000);
    alu("srl", SRL, 32'h8000_0000, 32'd31, 32'd1);
    alu("sll_mask", SLL, 32'd1, 32'd33, 32'd2);
    alu("slt", SLT, 32'hffff_ffff, 32'd1, 32'd1);
    alu("sltu", SLTU, 32'hffff_ffff, 32'd1, 32'd0);
    alu("and", AND, 32'hf0f0_f0f0, 32'hff00_ff00, 32'hf000_f000);
    alu("or", OR, 32'hf0f0_f0f0, 32'h0f00_0f00, 32'hfff0_fff0);
    alu("xor", XOR, 32'hffff_0000, 32'hff00_ff00, 32'h00ff_ff00);

    drv(ADD, 32'h40, 32'h20, 5'd0);
    wb_en = 1'b0; mem_w_en = 1'b1; br_taken = 1'b1; st_value = 32'hcafe_f00d;
    tick();
    chk("st_data", st_value_out, 32'hcafe_f00d);
    chk("st_flags", {28'd0, wb_en_out, mem_r_en_out, mem_w_en_out, br_taken_out}, 32'h3);
    chk("st_brt", br_target, 32'h0000_0120);

    drv(NOP, 32'h0, 32'h0, 5'd0);
    wb_en = 1'b0;
    tick();
    chk("bubble_prop", {alu_result[30:0], wb_en_out}, 32'd0);

    drv(ADD, 32'd7, 32'd8, 5'd6);
    flush = 1'b1;
    #1;
    tick();
    chk("flush_alu", {alu_result[30:0], wb_en_out}, 32'd0);

    multi("mul", MUL, 32'h0001_0003, 32'h0002_0005, 32'h000b_000f);
    multi("divu", DIVU, 32'd100, 32'd7, 32'd14);
    multi("remu", REMU, 32'd100, 32'd7, 32'd2);
    multi("divu_z", DIVU, 32'h1234_5678, 32'd0, 32'hffff_ffff);
    multi("remu_z", REMU, 32'd9, 32'd0, 32'd9);
    alu("after_multi", ADD, 32'd1, 32'd1, 32'd2);

    drv(DIVU, 32'd100, 32'd7, 5'd9);
    repeat (11) tick();
    chk("fl_pre_stall", 32'(stall_out), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_out), 32'd0);
    tick();
    chk("fl_bubble", {alu_result[30:0], wb_en_out}, 32'd0);
    alu("fl_idle_add", ADD, 32'd2, 32'd2, 32'd4);
    repeat (3) tick();
    chk("fl_no_wb", {alu_result[30:0], wb_en_out}, 32'd9);

    drv(MUL, 32'd3, 32'd5, 5'd9);
    repeat (6) tick();
    rstn = 1'b0;
    tick();
    chk("rmid_out", {alu_result[30:0], wb_en_out}, 32'd0);
    rstn = 1'b1;
    drv(ADD, 32'd2, 32'd2, 5'd3);
    chk("rmid_stall", 32'(stall_out), 32'd0);
    tick();
    chk("rmid_add", alu_result, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
